// File: rtl/output_logic_pkg.sv
// Shared types, constants and the hex -> 7-segment code table for the
// multiplexed display driver.
package output_logic_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] SEL_OFF = 4'hF;

  // One registered display state: anode select plus {dp,g,f,e,d,c,b,a}
  typedef struct packed {
    logic [NUM_DIGITS-1:0] sel;
    logic [7:0]            seg;
  } disp_t;

  // Active-low gfedcba; lowercase glyphs for b and d keep them distinct from 8 and 0
  function automatic logic [6:0] seg_decode(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/output_logic_seg7_decoder.sv
// Combinational hex digit to active-low gfedcba segment pattern.
module seg7_decoder
  import output_logic_pkg::*;
(
  input  logic [DIG_W-1:0] hex,
  output logic [6:0]       seg
);

  assign seg = seg_decode(hex);

endmodule

// File: rtl/output_logic.sv
// Four-digit common-anode 7-segment scan driver: prescaled digit rotation,
// per-slot blanking, registered one-hot-low anode select and segment bus.
module output_logic
  import output_logic_pkg::*;
#(
  parameter int         SCAN_DIV     = 100_000,
  parameter int         BLANK_CYCLES = 0,
  parameter logic [3:0] DP_MASK      = 4'b0000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] DIGIT_0,
  input  logic [3:0] DIGIT_1,
  input  logic [3:0] DIGIT_2,
  input  logic [3:0] DIGIT_3,
  output logic [7:0] SEGMENT,
  output logic [3:0] SELECT
);

  localparam int             PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  CNT_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] cnt;
  logic [1:0]    idx;
  logic          blank;
  disp_t         nxt;

  logic [NUM_DIGITS-1:0][DIG_W-1:0] digits;
  logic [NUM_DIGITS-1:0][6:0]       dec;

  assign digits = {DIGIT_3, DIGIT_2, DIGIT_1, DIGIT_0};

  // Decode every digit in parallel; the scan index only picks a result
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg7_decoder u_dec (
      .hex (digits[i]),
      .seg (dec[i])
    );
  end

  // Blank window at the head of each slot lets anode charge drain (anti-ghost)
  if (BLANK_CYCLES == 0) begin : g_noblank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = (cnt < PW'(BLANK_CYCLES));
  end

  always_comb begin
    nxt.sel = SEL_OFF;
    nxt.seg = SEG_OFF;
    if (!blank) begin
      nxt.sel[idx] = 1'b0;
      nxt.seg      = {~DP_MASK[idx], dec[idx]};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt     <= '0;
      idx     <= '0;
      SELECT  <= SEL_OFF;
      SEGMENT <= SEG_OFF;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      SELECT  <= nxt.sel;
      SEGMENT <= nxt.seg;
    end
  end

endmodule

// File: tb/tb_output_logic.sv
// Self-checking bench for output_logic: a plain scan instance and a
// blanking/decimal-point instance driven from the same inputs.
module tb_output_logic;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [7:0] seg_a, seg_b;
  logic [3:0] sel_a, sel_b;

  int errors = 0;
  int checks = 0;

  obs_t qa[$];
  obs_t qb[$];

  logic [7:0] tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0] sel_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  always #5 clk = ~clk;

  output_logic #(.SCAN_DIV(4), .BLANK_CYCLES(0), .DP_MASK(4'b0000)) u_a (
    .CLK(clk), .RST_N(rst_n), .DIGIT_0(d0), .DIGIT_1(d1), .DIGIT_2(d2), .DIGIT_3(d3),
    .SEGMENT(seg_a), .SELECT(sel_a));

  output_logic #(.SCAN_DIV(4), .BLANK_CYCLES(1), .DP_MASK(4'b0100)) u_b (
    .CLK(clk), .RST_N(rst_n), .DIGIT_0(d0), .DIGIT_1(d1), .DIGIT_2(d2), .DIGIT_3(d3),
    .SEGMENT(seg_b), .SELECT(sel_b));

  // Reference: what each edge should register, queued for the next falling edge
  function automatic obs_t mk(int cnt, int idx, logic [3:0] d, int blk, logic [3:0] dpm);
    obs_t o;
    o.sel = 4'hF;
    o.seg = 8'hFF;
    if (cnt >= blk) begin
      o.sel = sel_seq[idx];
      o.seg = tab[d];
      if (dpm[idx]) o.seg[7] = 1'b0;
    end
    return o;
  endfunction

  int mcnt = 0, midx = 0;
  always @(posedge clk or negedge rst_n) begin
    logic [3:0] dv;
    if (!rst_n) begin
      mcnt = 0;
      midx = 0;
    end else begin
      case (midx)
        0: dv = d0;
        1: dv = d1;
        2: dv = d2;
        default: dv = d3;
      endcase
      qa.push_back(mk(mcnt, midx, dv, 0, 4'b0000));
      qb.push_back(mk(mcnt, midx, dv, 1, 4'b0100));
      if (mcnt == 3) begin
        mcnt = 0;
        midx = (midx + 1) % 4;
      end else mcnt++;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      #1;
      checks++;
      if ({sel_a, seg_a} !== {4'hF, 8'hFF}) begin
        errors++;
        $display("FAIL reset_a cyc%0d: sel=%h seg=%h want sel=F seg=FF", k, sel_a, seg_a);
      end
      checks++;
      if ({sel_b, seg_b} !== {4'hF, 8'hFF}) begin
        errors++;
        $display("FAIL reset_b cyc%0d: sel=%h seg=%h want sel=F seg=FF", k, sel_b, seg_b);
      end
    end
  endtask

  task automatic test_scan();
    obs_t e;
    rst_n = 1'b0;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    @(negedge clk);
    qa.delete(); qb.delete();
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      logic [7:0] segs [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
      @(negedge clk);
      checks++;
      if ({sel_a, seg_a} !== {sel_seq[(k/4)%4], segs[(k/4)%4]}) begin
        errors++;
        $display("FAIL scan cyc%0d: sel=%h seg=%h want sel=%h seg=%h",
                 k, sel_a, seg_a, sel_seq[(k/4)%4], segs[(k/4)%4]);
      end
      checks++;
      if (qa.size() == 0 || qb.size() == 0) begin
        errors++;
        $display("FAIL scan_sb cyc%0d: scoreboard empty got 0 entries want 1", k);
      end else begin
        e = qb.pop_front();
        void'(qa.pop_front());
        if ({sel_b, seg_b} !== e) begin
          errors++;
          $display("FAIL scan_sb_b cyc%0d: got %h want %h", k, {sel_b, seg_b}, e);
        end
      end
    end
  endtask

  task automatic test_decode();
    obs_t e;
    int hits = 0;
    @(negedge clk);
    qa.delete(); qb.delete();
    for (int v = 0; v < 16; v++) begin
      d0 = 4'(v);
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL decode_sb v=%0d: scoreboard empty got 0 entries want 1", v);
        end else begin
          e = qa.pop_front();
          void'(qb.pop_front());
          if ({sel_a, seg_a} !== e) begin
            errors++;
            $display("FAIL decode_sb v=%0d: got %h want %h", v, {sel_a, seg_a}, e);
          end
        end
        if (sel_a == 4'hE) begin
          hits++;
          checks++;
          if (seg_a !== tab[v]) begin
            errors++;
            $display("FAIL decode v=%h: seg=%h want %h", v, seg_a, tab[v]);
          end
        end
      end
    end
    checks++;
    if (hits != 64) begin
      errors++;
      $display("FAIL decode_slots: digit0 slots seen=%0d want 64", hits);
    end
  endtask

  task automatic test_live_update();
    rst_n = 1'b0;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    checks++;
    if ({sel_a, seg_a} !== {4'hB, 8'hB0}) begin
      errors++;
      $display("FAIL live_before: sel=%h seg=%h want sel=B seg=B0", sel_a, seg_a);
    end
    d2 = 4'h0;
    @(negedge clk);
    checks++;
    if ({sel_a, seg_a} !== {4'hB, 8'hC0}) begin
      errors++;
      $display("FAIL live_after: sel=%h seg=%h want sel=B seg=C0", sel_a, seg_a);
    end
    d2 = 4'h3;
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (sel_a !== 4'hB) begin
      errors++;
      $display("FAIL areset_pre: sel=%h want B", sel_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel_a, seg_a, sel_b, seg_b} !== {4'hF, 8'hFF, 4'hF, 8'hFF}) begin
      errors++;
      $display("FAIL areset_now: a=%h/%h b=%h/%h want F/FF", sel_a, seg_a, sel_b, seg_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel_a, seg_a} !== {4'hE, 8'hF9}) begin
      errors++;
      $display("FAIL areset_restart: sel=%h seg=%h want sel=E seg=F9", sel_a, seg_a);
    end
  endtask

  task automatic test_blank_dp();
    logic [7:0] segs [4] = '{8'hF9, 8'hA4, 8'h30, 8'h99};
    obs_t want;
    rst_n = 1'b0;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      want = (k % 4 == 0) ? {4'hF, 8'hFF} : {sel_seq[(k/4)%4], segs[(k/4)%4]};
      checks++;
      if ({sel_b, seg_b} !== want) begin
        errors++;
        $display("FAIL blank_dp cyc%0d: sel=%h seg=%h want %h", k, sel_b, seg_b, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_live_update();
    test_async_reset();
    test_blank_dp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
